// File: rtl/sp_pkg.sv
// Package for the stack-pointer unit.
// Holds the op encodings seen on the op port and the FSM state type.
// Imported by sp_bounds_chk and sp_unit.
package sp_pkg;

    // Encodings 5-7 are decoded as NOP by the unit.
    typedef enum logic [2:0] {
        SP_OP_NOP  = 3'd0,
        SP_OP_PUSH = 3'd1,
        SP_OP_POP  = 3'd2,
        SP_OP_ADJ  = 3'd3,
        SP_OP_LOAD = 3'd4
    } sp_op_e;

    typedef enum logic {
        SP_RUN   = 1'b0,
        SP_FAULT = 1'b1
    } sp_state_e;

    // Candidate SP values carry two guard bits above AW.
    // The top bit is a sign, so results below 0 or above 2**AW-1 are
    // still ordered correctly against the bounds and never wrap.
    localparam int SP_GUARD_BITS = 2;

endpackage : sp_pkg

// File: rtl/sp_bounds_chk.sv
// Combinational bounds checker for a candidate stack-pointer value.
// Ports:
//   nsp   in  AW+2  signed candidate SP (guard bits included)
//   limit in  AW    lowest legal SP
//   top   in  AW    highest legal SP
//   legal out 1     limit <= nsp <= top
//   ovf   out 1     nsp < limit
//   unf   out 1     nsp > top
module sp_bounds_chk
    import sp_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic signed [AW+SP_GUARD_BITS-1:0] nsp,
    input  logic        [AW-1:0]               limit,
    input  logic        [AW-1:0]               top,
    output logic                               legal,
    output logic                               ovf,
    output logic                               unf
);

    // Bounds are zero-extended so both compares are signed against nsp.
    logic signed [AW+SP_GUARD_BITS-1:0] limit_x;
    logic signed [AW+SP_GUARD_BITS-1:0] top_x;

    assign limit_x = $signed({{SP_GUARD_BITS{1'b0}}, limit});
    assign top_x   = $signed({{SP_GUARD_BITS{1'b0}}, top});

    assign ovf   = (nsp < limit_x);
    assign unf   = (nsp > top_x);
    assign legal = !ovf && !unf;

endmodule : sp_bounds_chk

// File: rtl/sp_unit.sv
// Parametrised stack-pointer unit for the LSU (full-descending stack).
// SP points at the last pushed item; SP_TOP is the empty value.
// Executes PUSH/POP/ADJ/LOAD, emits the accessed address for PUSH/POP,
// bounds-checks every op and holds a sticky fault until fault_clr.
// Ports:
//   clk       in  1   clock, all state on posedge
//   rst       in  1   synchronous active-high reset
//   op_valid  in  1   op strobe, sampled only while ready
//   op        in  3   0 NOP, 1 PUSH, 2 POP, 3 ADJ, 4 LOAD, 5-7 NOP
//   op_data   in  AW  ADJ signed offset / LOAD new SP
//   fault_clr in  1   leave FAULT and clear ovf/unf
//   ready     out 1   1 in RUN, 0 in FAULT
//   sp_q      out AW  current SP
//   addr_q    out AW  address of the last accepted PUSH/POP
//   addr_vld  out 1   one-cycle pulse with each accepted PUSH/POP
//   empty     out 1   sp_q == SP_TOP
//   full      out 1   sp_q == SP_LIMIT
//   ovf       out 1   sticky: an op went below SP_LIMIT
//   unf       out 1   sticky: an op went above SP_TOP
module sp_unit
    import sp_pkg::*;
#(
    parameter int              AW       = 16,
    parameter logic [AW-1:0]   SP_TOP   = AW'(16'h7FFF),
    parameter logic [AW-1:0]   SP_LIMIT = AW'(16'h7F00),
    parameter int              STEP     = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          op_valid,
    input  logic [2:0]    op,
    input  logic [AW-1:0] op_data,
    input  logic          fault_clr,
    output logic          ready,
    output logic [AW-1:0] sp_q,
    output logic [AW-1:0] addr_q,
    output logic          addr_vld,
    output logic          empty,
    output logic          full,
    output logic          ovf,
    output logic          unf
);

    localparam int NW = AW + SP_GUARD_BITS;
    localparam logic signed [NW-1:0] STEP_X = NW'(STEP);

    sp_state_e state_q, state_d;

    logic signed [NW-1:0] sp_x;
    logic signed [NW-1:0] nsp;
    logic                 is_exec;
    logic                 nsp_legal;
    logic                 nsp_ovf;
    logic                 nsp_unf;

    logic [AW-1:0] sp_d;
    logic [AW-1:0] addr_d;
    logic          addr_vld_d;
    logic          ovf_d;
    logic          unf_d;

    assign sp_x = $signed({{SP_GUARD_BITS{1'b0}}, sp_q});

    // Candidate next SP; only the four executing ops raise is_exec.
    // NOTE: every signal assigned in an always_comb gets a default at the top,
    // otherwise paths that skip an assignment infer a latch.
    always_comb begin
        nsp     = sp_x;
        is_exec = 1'b0;
        case (op)
            SP_OP_PUSH: begin nsp = sp_x - STEP_X; is_exec = 1'b1; end
            SP_OP_POP:  begin nsp = sp_x + STEP_X; is_exec = 1'b1; end
            SP_OP_ADJ:  begin
                nsp     = sp_x + $signed({{SP_GUARD_BITS{op_data[AW-1]}}, op_data});
                is_exec = 1'b1;
            end
            SP_OP_LOAD: begin
                nsp     = $signed({{SP_GUARD_BITS{1'b0}}, op_data});
                is_exec = 1'b1;
            end
            default:    begin nsp = sp_x; is_exec = 1'b0; end
        endcase
    end

    sp_bounds_chk #(.AW(AW)) u_bounds (
        .nsp   (nsp),
        .limit (SP_LIMIT),
        .top   (SP_TOP),
        .legal (nsp_legal),
        .ovf   (nsp_ovf),
        .unf   (nsp_unf)
    );

    // Next-state and register-update logic.
    always_comb begin
        state_d    = state_q;
        sp_d       = sp_q;
        addr_d     = addr_q;
        addr_vld_d = 1'b0;
        ovf_d      = ovf;
        unf_d      = unf;
        case (state_q)
            SP_RUN: begin
                // fault_clr has no effect here; the op proceeds normally.
                if (op_valid && is_exec) begin
                    if (nsp_legal) begin
                        sp_d = nsp[AW-1:0];
                        if (op == SP_OP_PUSH) begin
                            addr_d     = nsp[AW-1:0];
                            addr_vld_d = 1'b1;
                        end else if (op == SP_OP_POP) begin
                            addr_d     = sp_q;
                            addr_vld_d = 1'b1;
                        end
                    end else begin
                        ovf_d   = ovf | nsp_ovf;
                        unf_d   = unf | nsp_unf;
                        state_d = SP_FAULT;
                    end
                end
            end
            SP_FAULT: begin
                // Any op presented in this state, including with fault_clr, is dropped.
                if (fault_clr) begin
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = SP_RUN;
                end
            end
            default: state_d = SP_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SP_RUN;
            sp_q     <= SP_TOP;
            addr_q   <= '0;
            addr_vld <= 1'b0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
        end else begin
            state_q  <= state_d;
            sp_q     <= sp_d;
            addr_q   <= addr_d;
            addr_vld <= addr_vld_d;
            ovf      <= ovf_d;
            unf      <= unf_d;
        end
    end

    assign ready = (state_q == SP_RUN);
    assign empty = (sp_q == SP_TOP);
    assign full  = (sp_q == SP_LIMIT);

endmodule : sp_unit

// File: tb/tb_sp_unit.sv
// Directed self-checking bench for sp_unit
// (AW=16, SP_TOP=7FFF, SP_LIMIT=7FF0, STEP=1).
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
module tb_sp_unit;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          op_valid = 1'b0;
    logic [2:0]    op = 3'd0;
    logic [AW-1:0] op_data = '0;
    logic          fault_clr = 1'b0;
    logic          ready;
    logic [AW-1:0] sp_q;
    logic [AW-1:0] addr_q;
    logic          addr_vld;
    logic          empty;
    logic          full;
    logic          ovf;
    logic          unf;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] NOP  = 3'd0;
    localparam logic [2:0] PUSH = 3'd1;
    localparam logic [2:0] POP  = 3'd2;
    localparam logic [2:0] ADJ  = 3'd3;
    localparam logic [2:0] LOAD = 3'd4;

    sp_unit #(
        .AW       (AW),
        .SP_TOP   (16'h7FFF),
        .SP_LIMIT (16'h7FF0),
        .STEP     (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op        (op),
        .op_data   (op_data),
        .fault_clr (fault_clr),
        .ready     (ready),
        .sp_q      (sp_q),
        .addr_q    (addr_q),
        .addr_vld  (addr_vld),
        .empty     (empty),
        .full      (full),
        .ovf       (ovf),
        .unf       (unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Present one op for one clock edge, then return the inputs to idle.
    task automatic step(input logic v, input logic [2:0] o, input logic [AW-1:0] d, input logic clr);
        op_valid  = v;
        op        = o;
        op_data   = d;
        fault_clr = clr;
        @(posedge clk);
        #1;
        op_valid  = 1'b0;
        op        = NOP;
        op_data   = '0;
        fault_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, NOP, '0, 1'b0);
        step(1'b0, NOP, '0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        // ---- 1: reset state and first PUSH ----
        do_reset();
        check("rst_sp",     32'(sp_q),     32'h7FFF);
        check("rst_empty",  32'(empty),    32'd1);
        check("rst_full",   32'(full),     32'd0);
        check("rst_ready",  32'(ready),    32'd1);
        check("rst_addr",   32'(addr_q),   32'h0000);
        check("rst_vld",    32'(addr_vld), 32'd0);
        check("rst_ovf",    32'(ovf),      32'd0);
        check("rst_unf",    32'(unf),      32'd0);

        step(1'b1, PUSH, '0, 1'b0);
        check("push1_sp",   32'(sp_q),     32'h7FFE);
        check("push1_addr", 32'(addr_q),   32'h7FFE);
        check("push1_vld",  32'(addr_vld), 32'd1);
        check("push1_emp",  32'(empty),    32'd0);

        step(1'b0, PUSH, '0, 1'b0);
        check("novalid_sp",  32'(sp_q),     32'h7FFE);
        check("novalid_vld", 32'(addr_vld), 32'd0);

        // ---- 2: fill to SP_LIMIT, then overflow ----
        for (int i = 0; i < 14; i++) step(1'b1, PUSH, '0, 1'b0);
        check("fill_sp",    32'(sp_q),     32'h7FF0);
        check("fill_full",  32'(full),     32'd1);
        check("fill_addr",  32'(addr_q),   32'h7FF0);

        step(1'b1, PUSH, '0, 1'b0);
        check("ovf_flag",   32'(ovf),      32'd1);
        check("ovf_unf",    32'(unf),      32'd0);
        check("ovf_ready",  32'(ready),    32'd0);
        check("ovf_sp",     32'(sp_q),     32'h7FF0);
        check("ovf_vld",    32'(addr_vld), 32'd0);

        step(1'b1, POP, '0, 1'b0);
        check("fault_pop_sp",  32'(sp_q),     32'h7FF0);
        check("fault_pop_vld", 32'(addr_vld), 32'd0);

        // clear with an op present: the op is dropped
        step(1'b1, POP, '0, 1'b1);
        check("clr_ready",  32'(ready),    32'd1);
        check("clr_ovf",    32'(ovf),      32'd0);
        check("clr_sp",     32'(sp_q),     32'h7FF0);
        check("clr_vld",    32'(addr_vld), 32'd0);

        // ---- 3: underflow from reset ----
        do_reset();
        step(1'b1, POP, '0, 1'b0);
        check("unf_flag",   32'(unf),      32'd1);
        check("unf_sp",     32'(sp_q),     32'h7FFF);
        check("unf_ready",  32'(ready),    32'd0);
        check("unf_vld",    32'(addr_vld), 32'd0);

        step(1'b1, POP, '0, 1'b0);
        check("unf_hold",   32'(unf),      32'd1);
        check("unf_hold_sp",32'(sp_q),     32'h7FFF);

        step(1'b0, NOP, '0, 1'b1);
        check("unf_clr_rdy",32'(ready),    32'd1);
        check("unf_clr",    32'(unf),      32'd0);

        // fault_clr in RUN: op still executes
        step(1'b1, PUSH, '0, 1'b1);
        check("runclr_sp",  32'(sp_q),     32'h7FFE);
        check("runclr_vld", 32'(addr_vld), 32'd1);

        // legal POP addresses the current SP
        step(1'b1, POP, '0, 1'b0);
        check("pop_sp",     32'(sp_q),     32'h7FFF);
        check("pop_addr",   32'(addr_q),   32'h7FFE);
        check("pop_vld",    32'(addr_vld), 32'd1);

        // op encoding 5 is a NOP
        step(1'b1, 3'd5, 16'h1234, 1'b0);
        check("op5_sp",     32'(sp_q),     32'h7FFF);
        check("op5_vld",    32'(addr_vld), 32'd0);
        check("op5_addr",   32'(addr_q),   32'h7FFE);

        // ---- 4: ADJ ----
        step(1'b1, LOAD, 16'h7FF8, 1'b0);
        check("ld_7ff8",    32'(sp_q),     32'h7FF8);
        step(1'b1, ADJ, 16'hFFFC, 1'b0);
        check("adj_m4",     32'(sp_q),     32'h7FF4);
        check("adj_m4_vld", 32'(addr_vld), 32'd0);
        step(1'b1, ADJ, 16'h000B, 1'b0);
        check("adj_p11",    32'(sp_q),     32'h7FFF);
        step(1'b1, ADJ, 16'h0001, 1'b0);
        check("adj_unf",    32'(unf),      32'd1);
        check("adj_unf_sp", 32'(sp_q),     32'h7FFF);
        check("adj_unf_rdy",32'(ready),    32'd0);
        step(1'b0, NOP, '0, 1'b1);
        check("adj_clr",    32'(unf),      32'd0);

        // ---- 5: LOAD ----
        step(1'b1, LOAD, 16'h7FF5, 1'b0);
        check("ld_sp",      32'(sp_q),     32'h7FF5);
        check("ld_vld",     32'(addr_vld), 32'd0);
        step(1'b1, LOAD, 16'h7FEF, 1'b0);
        check("ld_ovf",     32'(ovf),      32'd1);
        check("ld_ovf_sp",  32'(sp_q),     32'h7FF5);
        check("ld_ovf_unf", 32'(unf),      32'd0);

        // ---- 6: reset overrides op and fault_clr while in FAULT ----
        rst = 1'b1;
        step(1'b1, PUSH, '0, 1'b1);
        rst = 1'b0;
        check("rst6_sp",    32'(sp_q),     32'h7FFF);
        check("rst6_ovf",   32'(ovf),      32'd0);
        check("rst6_unf",   32'(unf),      32'd0);
        check("rst6_ready", 32'(ready),    32'd1);
        check("rst6_vld",   32'(addr_vld), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sp_unit
